// File: rtl/pulse_train_sequencer.sv
// Clock-counted pulse-train generator: on start, emits N pulses of H high / L low
// cycles, then strobes done for one cycle. All outputs are registered.
module pulse_train_sequencer #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] phase_reg, phase_next;
  logic [LEN_W-1:0] hm1_reg, hm1_next;
  logic [LEN_W-1:0] lm1_reg, lm1_next;
  logic [CNT_W-1:0] left_reg, left_next;

  // Phase lengths are stored as length-1 so a zero field naturally means one cycle.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    hm1_next   = hm1_reg;
    lm1_next   = lm1_reg;
    left_next  = left_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          if (pulse_count != '0) begin
            hm1_next   = (high_len == '0) ? '0 : high_len - LEN_ONE;
            lm1_next   = (low_len == '0) ? '0 : low_len - LEN_ONE;
            left_next  = pulse_count - CNT_ONE;
            phase_next = (high_len == '0) ? '0 : high_len - LEN_ONE;
            state_next = HIGH;
          end else begin
            state_next = DONE;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_next = IDLE;
          phase_next = '0;
          left_next  = '0;
        end else if (phase_reg == '0) begin
          phase_next = lm1_reg;
          state_next = LOW;
        end else begin
          phase_next = phase_reg - LEN_ONE;
        end
      end
      LOW: begin
        if (abort) begin
          state_next = IDLE;
          phase_next = '0;
          left_next  = '0;
        end else if (phase_reg == '0) begin
          if (left_reg != '0) begin
            left_next  = left_reg - CNT_ONE;
            phase_next = hm1_reg;
            state_next = HIGH;
          end else begin
            state_next = DONE;
          end
        end else begin
          phase_next = phase_reg - LEN_ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      hm1_reg     <= '0;
      lm1_reg     <= '0;
      left_reg    <= '0;
      signal      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      hm1_reg     <= hm1_next;
      lm1_reg     <= lm1_next;
      left_reg    <= left_next;
      signal      <= (state_next == HIGH);
      busy        <= (state_next == HIGH) || (state_next == LOW);
      done        <= (state_next == DONE);
      pulses_left <= left_next;
    end
  end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Bench for pulse_train_sequencer: expected waveforms are derived from the
// H/L/N timing formulas, queued at stimulus time and popped once per cycle.
module tb_pulse_train_sequencer;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] high_len = '0;
  logic [LEN_W-1:0] low_len = '0;
  logic [CNT_W-1:0] pulse_count = '0;
  logic             signal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;

  always #5 clk = ~clk;

  pulse_train_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .high_len(high_len), .low_len(low_len), .pulse_count(pulse_count),
    .signal(signal), .busy(busy), .done(done), .pulses_left(pulses_left)
  );

  // abort_j / s1 / s2: cycle offsets (from acceptance) in which abort or a stray start is driven.
  typedef struct {
    int h; int l; int n; int abort_j; int s1; int s2; bit chg;
  } vec_t;

  typedef struct {
    logic sig; logic busy; logic done; logic [CNT_W-1:0] left;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[8];

  function automatic exp_t mk(logic s, logic b, logic d, int left);
    exp_t e;
    e.sig  = s;
    e.busy = b;
    e.done = d;
    e.left = CNT_W'(left);
    return e;
  endfunction

  task automatic check(string name, int j);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: no expected record queued", name, j);
      return;
    end
    e = sb.pop_front();
    if (signal !== e.sig || busy !== e.busy || done !== e.done || pulses_left !== e.left) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: got sig=%0b busy=%0b done=%0b left=%0d, want sig=%0b busy=%0b done=%0b left=%0d",
               name, j, signal, busy, done, pulses_left, e.sig, e.busy, e.done, e.left);
    end
  endtask

  task automatic step(string name, int j);
    @(posedge clk);
    #1;
    check(name, j);
  endtask

  task automatic run_train(vec_t v);
    int he, le, p, np, last;
    he = (v.h == 0) ? 1 : v.h;
    le = (v.l == 0) ? 1 : v.l;
    p  = he + le;
    np = v.n * p;
    last = (v.abort_j >= 0) ? v.abort_j + 3 : np + 1;
    for (int j = 0; j <= last; j++) begin
      if (v.abort_j >= 0 && j > v.abort_j) sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      else if (j < np) sb.push_back(mk((j % p) < he, 1'b1, 1'b0, v.n - 1 - j / p));
      else if (j == np) sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      else sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    end
    high_len    = LEN_W'(v.h);
    low_len     = LEN_W'(v.l);
    pulse_count = CNT_W'(v.n);
    start = 1'b1;
    abort = 1'b0;
    for (int j = 0; j <= last; j++) begin
      step("train", j);
      start = (j == v.s1) || (j == v.s2);
      abort = (j == v.abort_j);
      if (v.chg) begin
        high_len    = LEN_W'($urandom);
        low_len     = LEN_W'($urandom);
        pulse_count = CNT_W'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    $display("train h=%0d l=%0d n=%0d abort_j=%0d chg=%0b: %0d cycles checked",
             v.h, v.l, v.n, v.abort_j, v.chg, last + 1);
  endtask

  initial begin
    vecs[0] = '{3, 3, 4, -1, 4, 24, 1'b0};  // stray starts in LOW and in DONE
    vecs[1] = '{0, 0, 2, -1, -1, -1, 1'b0}; // zero lengths act as 1
    vecs[2] = '{4, 4, 0, -1, -1, -1, 1'b0}; // N=0: immediate done
    vecs[3] = '{5, 2, 3, 8, -1, -1, 1'b0};  // abort in second HIGH
    vecs[4] = '{5, 2, 3, -1, -1, -1, 1'b1}; // config churn mid-train
    vecs[5] = '{2, 1, 3, -1, -1, -1, 1'b0}; // starts in the IDLE cycle after DONE
    vecs[6] = '{1, 1, 1, -1, -1, -1, 1'b0};
    vecs[7] = '{1, 7, 2, -1, 5, -1, 1'b0};

    // Reset holds everything idle even with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    high_len = 8'd2;
    pulse_count = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    check("reset", 0);
    start = 1'b0;
    rst_n = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    step("post_reset", 1);
    $display("reset sequence checked");

    for (int i = 0; i < 8; i++) run_train(vecs[i]);

    // start together with abort in IDLE must not launch a train.
    high_len = 8'd2;
    low_len = 8'd2;
    pulse_count = 8'd3;
    start = 1'b1;
    abort = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    step("start_abort", 0);
    start = 1'b0;
    abort = 1'b0;
    step("start_abort", 1);
    $display("start+abort in IDLE checked");

    // Reset asserted in the middle of a HIGH phase.
    high_len = 8'd5;
    low_len = 8'd1;
    pulse_count = 8'd2;
    start = 1'b1;
    sb.push_back(mk(1'b1, 1'b1, 1'b0, 1));
    sb.push_back(mk(1'b1, 1'b1, 1'b0, 1));
    step("rst_mid", 0);
    start = 1'b0;
    step("rst_mid", 1);
    rst_n = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    step("rst_mid", 2);
    rst_n = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    step("rst_mid", 3);
    $display("reset mid-HIGH checked");

    run_train(vecs[5]);

    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d expected records never compared", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
